// File: rtl/audio_pkg.sv
// Shared types and constants for the tone sequencer: FSM states, the
// constant note table, and the noise-step marker and LFSR seed.
package audio_pkg;

  typedef enum logic {IDLE, PLAY} state_t;

  localparam int          DEFAULT_SEQ_LEN = 16;
  localparam int          INC_W           = 16;
  localparam logic [15:0] NOISE_INC       = 16'hFFFF;
  localparam logic [15:0] LFSR_SEED       = 16'hACE1;

  // Phase increment for each sequence step. Zero marks a rest and
  // NOISE_INC marks a noise step. The first four entries form a short
  // loop that still makes sense when the sequence is cut to four steps.
  function automatic logic [INC_W-1:0] note_inc(input logic [7:0] idx);
    logic [INC_W-1:0] inc;
    case (idx)
      8'd0:    inc = 16'h4000;
      8'd1:    inc = 16'h0000;
      8'd2:    inc = 16'h8000;
      8'd3:    inc = NOISE_INC;
      8'd4:    inc = 16'h0A00;
      8'd5:    inc = 16'h0B40;
      8'd6:    inc = 16'h0CA0;
      8'd7:    inc = 16'h0000;
      8'd8:    inc = 16'h0D70;
      8'd9:    inc = 16'h0F00;
      8'd10:   inc = 16'h10E0;
      8'd11:   inc = NOISE_INC;
      8'd12:   inc = 16'h1400;
      8'd13:   inc = 16'h10E0;
      8'd14:   inc = 16'h0D70;
      8'd15:   inc = 16'h0000;
      default: inc = 16'h0000;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Frame divider: counts clocks within one PWM frame and pulses tick on the
// last clock of each frame. The count is held at zero whenever run is low
// so every new run starts a fresh, full-length frame.
module sample_tick_gen #(
  parameter int PWM_PERIOD = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int DIV_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PWM_PERIOD - 1);

  logic [DIV_W-1:0] div;

  assign tick = run && (div == DIV_LAST);

  // Frame counter: wraps at the end of the frame, cleared when not running.
  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// Looping note sequencer producing one enveloped square-wave sample per PWM
// frame for the 8-bit PWM DAC. Optional noise steps are enabled by defining
// AUDIO_NOISE_EN; without it, noise steps play as rests.
module tone_sequencer
  import audio_pkg::*;
#(
  parameter int PWM_PERIOD   = 255,
  parameter int PHASE_W      = 16,
  parameter int NOTE_SAMPLES = 4096,
  parameter int ENV_DIV      = 16,
  parameter int SEQ_LEN      = DEFAULT_SEQ_LEN
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  output logic [7:0]                 sample,
  output logic                       sample_strobe,
  output logic [$clog2(SEQ_LEN)-1:0] note_idx
);

  localparam int IDX_W  = $clog2(SEQ_LEN);
  localparam int NOTE_W = (NOTE_SAMPLES > 1) ? $clog2(NOTE_SAMPLES) : 1;
  localparam int ENV_W  = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
  localparam logic [NOTE_W-1:0] NOTE_LAST = NOTE_W'(NOTE_SAMPLES - 1);
  localparam logic [ENV_W-1:0]  ENV_LAST  = ENV_W'(ENV_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SEQ_LEN - 1);

  state_t              state;
  logic                run;
  logic                tick;
  logic [PHASE_W-1:0]  phase;
  logic [7:0]          env;
  logic [ENV_W-1:0]    env_cnt;
  logic [NOTE_W-1:0]   note_cnt;
  logic [INC_W-1:0]    raw_inc;
  logic                is_noise;
  logic [PHASE_W-1:0]  step_inc;
  logic [7:0]          tone_sample;
  logic [7:0]          next_sample;

  // The divider only runs while playing and enable is still high, so the
  // frame count is already cleared on the edge that leaves PLAY.
  assign run = (state == PLAY) && enable;

  sample_tick_gen #(
    .PWM_PERIOD(PWM_PERIOD)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .tick (tick)
  );

  assign raw_inc     = note_inc(8'(note_idx));
  assign is_noise    = (raw_inc == NOISE_INC);
  assign step_inc    = is_noise ? '0 : PHASE_W'(raw_inc);
  assign tone_sample = phase[PHASE_W-1] ? env : 8'h00;

`ifdef AUDIO_NOISE_EN
  logic [15:0] lfsr;

  assign next_sample = is_noise ? (lfsr[7:0] & env) : tone_sample;

  // Noise source: reseeded on entry to PLAY, stepped once per sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (state == IDLE && enable) begin
      lfsr <= LFSR_SEED;
    end else if (run && tick) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end
`else
  assign next_sample = is_noise ? 8'h00 : tone_sample;
`endif

  // Playback FSM with phase, envelope and sequence stepping on each frame tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      sample        <= 8'h00;
      sample_strobe <= 1'b0;
      note_idx      <= '0;
      phase         <= '0;
      env           <= 8'hFF;
      env_cnt       <= '0;
      note_cnt      <= '0;
    end else begin
      sample_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state    <= PLAY;
            note_cnt <= '0;
            note_idx <= '0;
            phase    <= '0;
            env      <= 8'hFF;
            env_cnt  <= '0;
          end
        end
        PLAY: begin
          if (!enable) begin
            state  <= IDLE;
            sample <= 8'h00;
          end else if (tick) begin
            sample_strobe <= 1'b1;
            sample        <= next_sample;
            if (note_cnt == NOTE_LAST) begin
              note_cnt <= '0;
              note_idx <= (note_idx == IDX_LAST) ? '0 : note_idx + 1'b1;
              phase    <= '0;
              env      <= 8'hFF;
              env_cnt  <= '0;
            end else begin
              note_cnt <= note_cnt + 1'b1;
              phase    <= phase + step_inc;
              if (env_cnt == ENV_LAST) begin
                env_cnt <= '0;
                if (env != 8'h00) begin
                  env <= env - 1'b1;
                end
              end else begin
                env_cnt <= env_cnt + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with a shortened configuration:
// 4-clock frames, 8 samples per note, envelope step every 2 samples,
// 4-step sequence {4000h, rest, 8000h, noise}.
module tb_tone_sequencer;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] sample;
  logic       sample_strobe;
  logic [1:0] note_idx;

  int testsRun    = 0;
  int testsFailed = 0;
  logic [15:0] lfsrModel;

  // Hand-computed samples for note 0 (inc 4000h) and note 2 (inc 8000h).
  localparam logic [7:0] NOTE0_EXP [8] = '{8'h00, 8'h00, 8'hFE, 8'hFE, 8'h00, 8'h00, 8'hFC, 8'hFC};
  localparam logic [7:0] NOTE2_EXP [8] = '{8'h00, 8'hFF, 8'h00, 8'hFE, 8'h00, 8'hFD, 8'h00, 8'hFC};

  tone_sequencer #(
    .PWM_PERIOD  (4),
    .PHASE_W     (16),
    .NOTE_SAMPLES(8),
    .ENV_DIV     (2),
    .SEQ_LEN     (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sample       (sample),
    .sample_strobe(sample_strobe),
    .note_idx     (note_idx)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rn);
    enable = en;
    rst_n  = rn;
  endtask

  function automatic logic [15:0] lfsrStep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Expected sample for the idx-th strobe since entering PLAY.
  function automatic logic [7:0] expSample(input int idx, input logic [15:0] lfsrNow);
    int note = (idx / 8) % 4;
    int j    = idx % 8;
    logic [7:0] envNow = 8'hFF - 8'(j / 2);
    logic [7:0] e;
    case (note)
      0:       e = NOTE0_EXP[j];
      2:       e = NOTE2_EXP[j];
`ifdef AUDIO_NOISE_EN
      3:       e = lfsrNow[7:0] & envNow;
`endif
      default: e = 8'h00;
    endcase
    if (lfsrNow == 16'h0000 && envNow == 8'h00) e = 8'h00;
    return e;
  endfunction

  // Waits at most 20 clocks for the next strobe; returns clocks waited.
  task automatic waitStrobe(output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!sample_strobe && gap < 20);
    if (!sample_strobe) checkOutput("strobe_timeout", 32'd0, 32'd1);
  endtask

  // Checks count strobes: spacing, sample value and note index.
  task automatic playStrobes(input int count, input int firstGap);
    int gap;
    int expGap = firstGap;
    for (int i = 0; i < count; i++) begin
      waitStrobe(gap);
      checkOutput($sformatf("gap_%0d", i), 32'(gap), 32'(expGap));
      checkOutput($sformatf("sample_%0d", i), 32'(sample), 32'(expSample(i, lfsrModel)));
      checkOutput($sformatf("note_idx_%0d", i), 32'(note_idx), 32'(((i + 1) / 8) % 4));
      lfsrModel = lfsrStep(lfsrModel);
      expGap = 4;
      if (i == 0) begin
        @(negedge clk);
        checkOutput("strobe_width", 32'(sample_strobe), 32'd0);
        expGap = 3;
      end
    end
  endtask

  initial begin
    int strobes;

    // Reset held, then idle with enable low: no activity expected.
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset_sample", 32'(sample), 32'd0);
    checkOutput("reset_strobe", 32'(sample_strobe), 32'd0);
    checkOutput("reset_note_idx", 32'(note_idx), 32'd0);
    applyStimulus(1'b0, 1'b1);
    strobes = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (sample_strobe) strobes++;
    end
    checkOutput("idle_strobes", 32'(strobes), 32'd0);
    checkOutput("idle_sample", 32'(sample), 32'd0);
    checkOutput("idle_note_idx", 32'(note_idx), 32'd0);

    // Play 50 strobes: a full loop, the wrap back to note 0, into note 2.
    lfsrModel = 16'hACE1;
    applyStimulus(1'b1, 1'b1);
    playStrobes(50, 5);

    // Drop enable when the frame counter is at 2 inside note 2.
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    checkOutput("drop_sample", 32'(sample), 32'd0);
    checkOutput("drop_strobe", 32'(sample_strobe), 32'd0);
    strobes = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (sample_strobe) strobes++;
    end
    checkOutput("drop_idle_strobes", 32'(strobes), 32'd0);

    // Re-enable: restart from note 0 with a fresh envelope, run into note 3.
    lfsrModel = 16'hACE1;
    applyStimulus(1'b1, 1'b1);
    playStrobes(28, 5);

    // Assert reset on the edge where the next strobe would land.
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    checkOutput("midreset_strobe", 32'(sample_strobe), 32'd0);
    checkOutput("midreset_sample", 32'(sample), 32'd0);
    checkOutput("midreset_note_idx", 32'(note_idx), 32'd0);
    applyStimulus(1'b0, 1'b1);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
